// File: rtl/sound_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sound_event_arbiter
//  Description : Latches up to four sound-event request pulses and schedules
//                them onto a single SongPlayer voice. The highest pending
//                index is granted a fixed play window followed by a silent
//                gap. A higher-priority event may abort a lower one that is
//                still playing, and mute suppresses all playback.
//  Ports       : clk       - system clock
//                reset     - synchronous, active-high reset
//                req[3:0]  - request pulses, req[3] highest, req[i] -> code i
//                mute      - level, clears pending and blocks playback
//                sound     - granted event code to SongPlayer.sound
//                playSound - high for the whole play window
//                grant     - one-cycle one-hot ack when playSound rises
//                pending   - latched, not-yet-granted requests
//                busy      - high whenever the scheduler is not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module sound_event_arbiter #(
  parameter int PLAY_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 1_000_000,
  parameter bit PREEMPT     = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       mute,
  output logic [1:0] sound,
  output logic       playSound,
  output logic [3:0] grant,
  output logic [3:0] pending,
  output logic       busy
);

  localparam int MAX_CYCLES = (PLAY_CYCLES > GAP_CYCLES) ? PLAY_CYCLES : GAP_CYCLES;
  localparam int TIMER_W    = $clog2(MAX_CYCLES + 1);
  localparam logic [TIMER_W-1:0] PLAY_LOAD = TIMER_W'(PLAY_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD  = TIMER_W'(GAP_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t             state;
  logic [TIMER_W-1:0] timer;

  logic [3:0] cand;
  logic [1:0] sel;
  logic [3:0] sel_onehot;
  logic       any_cand;
  logic       start;
  logic       preempt_hit;
  logic [3:0] clear;

  // Candidates include this cycle's requests so an idle arbiter reacts with
  // one cycle of latency; mute hides everything.
  always_comb begin
    cand = mute ? 4'b0000 : (pending | req);
    sel  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (cand[i]) sel = 2'(i);
    end
    sel_onehot  = 4'b0001 << sel;
    any_cand    = |cand;
    start       = (state == IDLE) && any_cand;
    preempt_hit = (PREEMPT != 1'b0) && any_cand && (sel > sound);
    // The granted bit is cleared on the decision edge, so a fresh request
    // arriving while grant is high re-latches instead of being lost.
    clear       = mute ? 4'b1111 : (start ? sel_onehot : 4'b0000);
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      sound     <= 2'd0;
      playSound <= 1'b0;
      grant     <= 4'b0000;
      pending   <= 4'b0000;
    end else begin
      pending <= (pending | req) & ~clear;
      grant   <= 4'b0000;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= PLAY;
            sound     <= sel;
            playSound <= 1'b1;
            grant     <= sel_onehot;
            timer     <= PLAY_LOAD;
          end
        end
        PLAY: begin
          // Aborts (mute / preemption) take precedence over normal expiry;
          // both paths lead to the same gap. The aborted code is not requeued.
          if (mute || preempt_hit || (timer == '0)) begin
            state     <= GAP;
            playSound <= 1'b0;
            timer     <= GAP_LOAD;
          end else begin
            timer <= timer - TIMER_ONE;
          end
        end
        GAP: begin
          if (timer == '0) begin
            state <= IDLE;
          end else begin
            timer <= timer - TIMER_ONE;
          end
        end
        default: begin
          state     <= IDLE;
          playSound <= 1'b0;
          timer     <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
